// File: rtl/mem_stage_module.sv
// rtl/mem_stage_module.sv - ARM pipeline memory stage with word-addressed data memory and MEM/WB register (wait states under MEM_WAIT_STATES_EN)
module mem_stage_module #(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDRESS_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_LEN-1:0] pc_in,
  input  logic [31:0]            alu_result_in,
  input  logic [31:0]            val_rm_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic                   wb_en_in,
  input  logic [3:0]             dest_in,
  output logic                   stall,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [31:0]            alu_result_out,
  output logic [31:0]            mem_data_out,
  output logic                   mem_r_en_out,
  output logic                   wb_en_out,
  output logic [3:0]             dest_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_mem [0:DEPTH-1];
  logic [31:0]   w_offset;
  logic [AW-1:0] w_index;
  logic          w_is_load;
  logic [31:0]   w_rdata;
  logic          w_stall;
  logic          w_mem_we;
  logic          w_unused_addr;

  // Byte address relative to the window base; bits [1:0] and bits above the array size are dropped so addresses wrap.
  assign w_offset      = alu_result_in - 32'(BASE_ADDR);
  assign w_index       = w_offset[AW+1:2];
  assign w_unused_addr = ^{w_offset[31:AW+2], w_offset[1:0]};

  // A simultaneous read and write request is handled as a store, so only a pure load returns array data.
  assign w_is_load = mem_r_en_in & ~mem_w_en_in;
  assign w_rdata   = w_is_load ? r_mem[w_index] : 32'd0;

`ifdef MEM_WAIT_STATES_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_access;
  logic          w_complete;

  assign w_access   = mem_r_en_in | mem_w_en_in;
  assign w_complete = (r_state == S_BUSY) && (r_cnt == '0);

  // Stall covers the issue cycle and every BUSY cycle except the completing one.
  always_comb begin
    w_stall = 1'b0;
    if (r_state == S_IDLE) begin
      w_stall = w_access;
    end else begin
      w_stall = (r_cnt != '0);
    end
  end

  // Only the completing cycle writes, so each store commits once; reset drops a pending store.
  assign w_mem_we = w_complete & mem_w_en_in & ~rst;

  // Wait-state sequencer: IDLE -> BUSY on an access, count down, return to IDLE on the completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_state <= S_BUSY;
            r_cnt   <= CW'(WAIT_CYCLES - 1);
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
`else
  logic w_unused_wait;

  // Single-cycle memory: no stall, a store writes on the edge following its presentation.
  assign w_stall       = 1'b0;
  assign w_mem_we      = mem_w_en_in & ~rst;
  assign w_unused_wait = |32'(WAIT_CYCLES);
`endif

  assign stall = w_stall;

  // Data array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_index] <= val_rm_in;
    end
  end

  // MEM/WB register: bubble while stalled (fields held, enables cleared), capture otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out         <= '0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      mem_r_en_out   <= 1'b0;
      wb_en_out      <= 1'b0;
      dest_out       <= '0;
    end else if (w_stall) begin
      mem_r_en_out <= 1'b0;
      wb_en_out    <= 1'b0;
    end else begin
      pc_out         <= pc_in;
      alu_result_out <= alu_result_in;
      mem_data_out   <= w_rdata;
      mem_r_en_out   <= mem_r_en_in;
      wb_en_out      <= wb_en_in;
      dest_out       <= dest_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_module.sv
// tb/tb_mem_stage_module.sv - directed self-checking bench for mem_stage_module
`timescale 1ns/1ps
module tb_mem_stage_module;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] alu_result_in;
  logic [31:0] val_rm_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        wb_en_in;
  logic [3:0]  dest_in;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data_out;
  logic        mem_r_en_out;
  logic        wb_en_out;
  logic [3:0]  dest_out;

  int checks   = 0;
  int failures = 0;

`ifdef MEM_WAIT_STATES_EN
  localparam int EXP_STALL = 2;
`else
  localparam int EXP_STALL = 0;
`endif

  always #5 clk = ~clk;

  mem_stage_module #(
    .DEPTH(64),
    .BASE_ADDR(1024),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_in(pc_in),
    .alu_result_in(alu_result_in),
    .val_rm_in(val_rm_in),
    .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in),
    .wb_en_in(wb_en_in),
    .dest_in(dest_in),
    .stall(stall),
    .pc_out(pc_out),
    .alu_result_out(alu_result_out),
    .mem_data_out(mem_data_out),
    .mem_r_en_out(mem_r_en_out),
    .wb_en_out(wb_en_out),
    .dest_out(dest_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    checks++;
    if (stall !== 1'b0 || pc_out !== 32'd0 || alu_result_out !== 32'd0 ||
        mem_data_out !== 32'd0 || mem_r_en_out !== 1'b0 || wb_en_out !== 1'b0 ||
        dest_out !== 4'd0) begin
      failures++;
      $error("FAIL %s outputs not in reset state", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input string tag, input logic r, input logic w,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic wb, input logic [3:0] dest);
    int n;
    n             = 0;
    pc_in         = pc_in + 32'd4;
    alu_result_in = addr;
    val_rm_in     = data;
    mem_r_en_in   = r;
    mem_w_en_in   = w;
    wb_en_in      = wb;
    dest_in       = dest;
    #1;
    while (stall === 1'b1 && n < 20) begin
      n++;
      cyc();
      chk({tag, "_bubble_wb"}, 32'(wb_en_out), 32'd0);
      chk({tag, "_bubble_rd"}, 32'(mem_r_en_out), 32'd0);
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $error("FAIL %s_wait_expired stall still high after %0d cycles", tag, n);
    end
    cyc();
    chk({tag, "_stall_cycles"}, 32'(n), 32'(EXP_STALL));
    chk({tag, "_pc"}, pc_out, pc_in);
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    pc_in         = 32'd0;
    alu_result_in = 32'd0;
    val_rm_in     = 32'd0;
    mem_r_en_in   = 1'b0;
    mem_w_en_in   = 1'b0;
    wb_en_in      = 1'b0;
    dest_in       = 4'd0;
    cyc();
    cyc();
    chk_reset_state("rst_state");
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_alu", alu_result_out, 32'd0);
    chk("rst_data", mem_data_out, 32'd0);
    chk("rst_rd", 32'(mem_r_en_out), 32'd0);
    chk("rst_wb", 32'(wb_en_out), 32'd0);
    chk("rst_dest", 32'(dest_out), 32'd0);

    rst           = 1'b0;
    pc_in         = 32'h100;
    alu_result_in = 32'h1234;
    wb_en_in      = 1'b1;
    dest_in       = 4'd5;
    #1;
    chk("pass_stall", 32'(stall), 32'd0);
    cyc();
    chk("pass_alu", alu_result_out, 32'h1234);
    chk("pass_wb", 32'(wb_en_out), 32'd1);
    chk("pass_dest", 32'(dest_out), 32'd5);
    chk("pass_pc", pc_out, 32'h100);
    chk("pass_rd", 32'(mem_r_en_out), 32'd0);
    chk("pass_stall_after", 32'(stall), 32'd0);

    do_access("store1", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 4'd0);
    chk("store1_wb", 32'(wb_en_out), 32'd0);
    chk("store1_alu", alu_result_out, 32'd1028);

    do_access("load1", 1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 4'd3);
    chk("load1_data", mem_data_out, 32'hDEADBEEF);
    chk("load1_rd", 32'(mem_r_en_out), 32'd1);
    chk("load1_wb", 32'(wb_en_out), 32'd1);
    chk("load1_dest", 32'(dest_out), 32'd3);

    do_access("wrap_st", 1'b0, 1'b1, 32'd1280, 32'h55, 1'b0, 4'd0);
    do_access("wrap_ld", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 4'd1);
    chk("wrap_data", mem_data_out, 32'h55);
    do_access("keep_ld", 1'b1, 1'b0, 32'd1030, 32'd0, 1'b1, 4'd2);
    chk("keep_data", mem_data_out, 32'hDEADBEEF);

    do_access("prior_st", 1'b0, 1'b1, 32'd1032, 32'h11, 1'b0, 4'd0);
    pc_in         = pc_in + 32'd4;
    alu_result_in = 32'd1032;
    val_rm_in     = 32'hAA;
    mem_w_en_in   = 1'b1;
    wb_en_in      = 1'b0;
`ifdef MEM_WAIT_STATES_EN
    #1;
    chk("rstmid_stall1", 32'(stall), 32'd1);
    cyc();
    chk("rstmid_stall2", 32'(stall), 32'd1);
    rst = 1'b1;
    mem_w_en_in = 1'b0;
    cyc();
`else
    rst = 1'b1;
    cyc();
    mem_w_en_in = 1'b0;
`endif
    rst = 1'b0;
    #1;
    chk("rstmid_stall_after", 32'(stall), 32'd0);
    chk("rstmid_alu", alu_result_out, 32'd0);
    chk("rstmid_pc", pc_out, 32'd0);
    do_access("rstmid_ld", 1'b1, 1'b0, 32'd1032, 32'd0, 1'b1, 4'd4);
    chk("rstmid_data", mem_data_out, 32'h11);

    do_access("b2b_st", 1'b0, 1'b1, 32'd1036, 32'h12345678, 1'b0, 4'd0);
    do_access("b2b_ld", 1'b1, 1'b0, 32'd1036, 32'd0, 1'b1, 4'd6);
    chk("b2b_data", mem_data_out, 32'h12345678);
    chk("b2b_rd", 32'(mem_r_en_out), 32'd1);

    do_access("both_st", 1'b1, 1'b1, 32'd1040, 32'h77, 1'b0, 4'd0);
    chk("both_data", mem_data_out, 32'd0);
    do_access("both_ld", 1'b1, 1'b0, 32'd1040, 32'd0, 1'b1, 4'd7);
    chk("both_ld_data", mem_data_out, 32'h77);

    alu_result_in = 32'hCAFE;
    wb_en_in      = 1'b1;
    dest_in       = 4'd9;
    #1;
    chk("tail_stall", 32'(stall), 32'd0);
    cyc();
    chk("tail_alu", alu_result_out, 32'hCAFE);
    chk("tail_rd", 32'(mem_r_en_out), 32'd0);
    chk("tail_dest", 32'(dest_out), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
